// File: rtl/spi_master_apb_regif.sv
// APB register front end for the SPI master: configuration registers,
// command strobes and wait-stated TX/RX FIFO access with timeout.
module spi_master_apb_regif #(
    parameter int APB_ADDR_WIDTH   = 12,
    parameter int LOG_BUFFER_DEPTH = 4,
    parameter int NUM_CS           = 4,
    parameter int CLKDIV_WIDTH     = 16,
    parameter int WAIT_TIMEOUT     = 255
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
    input  logic [31:0]                 PWDATA,
    input  logic                        PWRITE,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    output logic [31:0]                 PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic [CLKDIV_WIDTH-1:0]     spi_clk_div,
    output logic                        spi_clk_div_valid,
    output logic                        spi_cpol,
    output logic                        spi_cpha,
    output logic [31:0]                 spi_cmd,
    output logic [31:0]                 spi_addr,
    output logic [5:0]                  spi_cmd_len,
    output logic [5:0]                  spi_addr_len,
    output logic [15:0]                 spi_data_len,
    output logic [15:0]                 spi_dummy_rd,
    output logic [15:0]                 spi_dummy_wr,
    output logic [NUM_CS-1:0]           spi_csreg,
    output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_tx,
    output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_rx,
    output logic                        spi_int_en,
    input  logic [31:0]                 spi_status,
    input  logic [31:0]                 spi_int_status,
    input  logic                        spi_busy,
    output logic                        spi_rd,
    output logic                        spi_wr,
    output logic                        spi_qrd,
    output logic                        spi_qwr,
    output logic                        spi_swrst,
    output logic [31:0]                 spi_data_tx,
    output logic                        spi_data_tx_valid,
    input  logic                        spi_data_tx_ready,
    input  logic [31:0]                 spi_data_rx,
    input  logic                        spi_data_rx_valid,
    output logic                        spi_data_rx_ready
);

    localparam int CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam int TW = LOG_BUFFER_DEPTH + 1;

    typedef enum logic [1:0] {IDLE, TX_WAIT, RX_WAIT} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [3:0]     idx;
    logic [3:0]     errsta, err_set, w1c;
    logic [31:0]    rdata;
    logic           access, is_tx, is_rx, timeout;
    logic           tx_done, rx_done, bad, busy_rej, wr_ok, rd_ok;
    logic           unused_addr;

    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

    // Reset masks any in-flight access so nothing is pushed or popped.
    assign access = PSEL & PENABLE & ~HRESET;
    assign idx    = PADDR[5:2];
    assign is_tx  = access & PWRITE & (idx == 4'h6);
    assign is_rx  = access & ~PWRITE & (idx == 4'h8);

    assign timeout = (state != IDLE) && (cnt == CW'(WAIT_TIMEOUT));
    assign tx_done = is_tx & (spi_data_tx_ready | timeout);
    assign rx_done = is_rx & (spi_data_rx_valid | timeout);

    always_comb begin
        bad = 1'b0;
        case (idx)
            4'h6:                   bad = ~PWRITE;
            4'h8, 4'hA:             bad = PWRITE;
            4'h7, 4'hD, 4'hE, 4'hF: bad = 1'b1;
            default:                bad = 1'b0;
        endcase
        bad = bad & access;
    end

    assign busy_rej = access & PWRITE & (idx == 4'h0)
                    & spi_busy & (|PWDATA[3:0]);
    assign wr_ok    = access & PWRITE & ~bad & ~busy_rej;
    assign rd_ok    = access & ~PWRITE & ~bad;

    assign w1c     = (wr_ok && idx == 4'hC) ? PWDATA[3:0] : 4'b0;
    assign err_set = {bad, busy_rej, is_rx & timeout, is_tx & timeout};

    assign PREADY  = ~((is_tx & ~tx_done) | (is_rx & ~rx_done));
    assign PSLVERR = bad | busy_rej | ((is_tx | is_rx) & timeout);
    assign PRDATA  = rd_ok ? rdata : 32'h0;

    assign spi_data_tx       = is_tx ? PWDATA : 32'h0;
    assign spi_data_tx_valid = is_tx & ~timeout;
    assign spi_data_rx_ready = is_rx & spi_data_rx_valid & ~timeout;

    always_comb begin
        state_n = IDLE;
        cnt_n   = '0;
        if (is_tx && !tx_done) begin
            state_n = TX_WAIT;
            cnt_n   = cnt + 1'b1;
        end else if (is_rx && !rx_done) begin
            state_n = RX_WAIT;
            cnt_n   = cnt + 1'b1;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (idx)
            4'h0: rdata = spi_status;
            4'h1: rdata[CLKDIV_WIDTH-1:0] = spi_clk_div;
            4'h2: rdata = spi_cmd;
            4'h3: rdata = spi_addr;
            4'h4: rdata = {spi_data_len, 2'b0, spi_addr_len,
                           2'b0, spi_cmd_len};
            4'h5: rdata = {spi_dummy_wr, spi_dummy_rd};
            4'h8: rdata = spi_data_rx_ready ? spi_data_rx : 32'h0;
            4'h9: begin
                rdata[TW-1:0]   = spi_int_th_tx;
                rdata[8 +: TW]  = spi_int_th_rx;
                rdata[31]       = spi_int_en;
            end
            4'hA: rdata = spi_int_status;
            4'hB: rdata = {30'b0, spi_cpha, spi_cpol};
            4'hC: rdata = {28'b0, errsta};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state             <= IDLE;
            cnt               <= '0;
            errsta            <= '0;
            spi_clk_div       <= '0;
            spi_clk_div_valid <= 1'b0;
            spi_cpol          <= 1'b0;
            spi_cpha          <= 1'b0;
            spi_cmd           <= '0;
            spi_addr          <= '0;
            spi_cmd_len       <= '0;
            spi_addr_len      <= '0;
            spi_data_len      <= '0;
            spi_dummy_rd      <= '0;
            spi_dummy_wr      <= '0;
            spi_csreg         <= '0;
            spi_int_th_tx     <= '0;
            spi_int_th_rx     <= '0;
            spi_int_en        <= 1'b0;
            spi_rd            <= 1'b0;
            spi_wr            <= 1'b0;
            spi_qrd           <= 1'b0;
            spi_qwr           <= 1'b0;
            spi_swrst         <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            errsta            <= (errsta & ~w1c) | err_set;
            spi_clk_div_valid <= 1'b0;
            spi_rd            <= 1'b0;
            spi_wr            <= 1'b0;
            spi_qrd           <= 1'b0;
            spi_qwr           <= 1'b0;
            // Soft reset is honoured even when the command bits are rejected.
            spi_swrst <= access & PWRITE & (idx == 4'h0) & PWDATA[4];
            if (wr_ok) begin
                case (idx)
                    4'h0: begin
                        spi_rd    <= PWDATA[0];
                        spi_wr    <= PWDATA[1];
                        spi_qrd   <= PWDATA[2];
                        spi_qwr   <= PWDATA[3];
                        spi_csreg <= PWDATA[8 +: NUM_CS];
                    end
                    4'h1: begin
                        spi_clk_div       <= PWDATA[CLKDIV_WIDTH-1:0];
                        spi_clk_div_valid <= 1'b1;
                    end
                    4'h2: spi_cmd  <= PWDATA;
                    4'h3: spi_addr <= PWDATA;
                    4'h4: begin
                        spi_cmd_len  <= PWDATA[5:0];
                        spi_addr_len <= PWDATA[13:8];
                        spi_data_len <= PWDATA[31:16];
                    end
                    4'h5: begin
                        spi_dummy_rd <= PWDATA[15:0];
                        spi_dummy_wr <= PWDATA[31:16];
                    end
                    4'h9: begin
                        spi_int_th_tx <= PWDATA[TW-1:0];
                        spi_int_th_rx <= PWDATA[8 +: TW];
                        spi_int_en    <= PWDATA[31];
                    end
                    4'hB: begin
                        spi_cpol <= PWDATA[0];
                        spi_cpha <= PWDATA[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
